// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: word width,
// FSM and grant encodings, and the round-robin pick.
package mem_arbiter_pkg;

    localparam int WORD_SIZE = 16;

    typedef logic [WORD_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    // On a conflict the port that did not win last time gets the bus.
    function automatic grant_e pick_grant(input logic i_req, input logic d_req,
                                          input grant_e last);
        if (i_req && d_req)
            return (last == GRANT_I) ? GRANT_D : GRANT_I;
        return d_req ? GRANT_D : GRANT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-port and memory-strobe signals of the arbiter. The bidirectional
// memory data bus stays a plain port on the arbiter.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic  i_read;
    word_t i_address;
    word_t i_data;
    logic  i_ready;
    logic  stall_if;

    logic  d_read;
    logic  d_write;
    word_t d_address;
    word_t d_wdata;
    word_t d_rdata;
    logic  d_ready;
    logic  stall_mem;

    logic  m_read;
    logic  m_write;
    word_t m_address;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
        output i_data, i_ready, stall_if, d_rdata, d_ready, stall_mem,
               m_read, m_write, m_address
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
        input  i_data, i_ready, stall_if, d_rdata, d_ready, stall_mem,
               m_read, m_write, m_address
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between the fetch port
// and the data port: IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP (ready pulse).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_arbiter_if.slave         bus,
    inout  wire [WORD_SIZE-1:0]  m_data
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    arb_state_e   state;
    grant_e       grant;
    grant_e       last_grant;
    grant_e       next_grant;
    logic [CW-1:0] cnt;

    logic  m_read_q;
    logic  m_write_q;
    word_t m_address_q;
    word_t wdata_q;
    word_t i_data_q;
    word_t d_rdata_q;
    logic  i_ready_q;
    logic  d_ready_q;

    logic d_req;

    assign d_req = bus.d_read | bus.d_write;

    always_comb next_grant = pick_grant(bus.i_read, d_req, last_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            grant       <= GRANT_I;
            last_grant  <= GRANT_I;
            cnt         <= '0;
            m_read_q    <= 1'b0;
            m_write_q   <= 1'b0;
            m_address_q <= '0;
            wdata_q     <= '0;
            i_data_q    <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (bus.i_read || d_req) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        cnt        <= CW'(MEM_LATENCY - 1);
                        state      <= ARB_ACCESS;
                        if (next_grant == GRANT_D) begin
                            // read and write together is handled as a write
                            m_read_q    <= ~bus.d_write;
                            m_write_q   <= bus.d_write;
                            m_address_q <= bus.d_address;
                            wdata_q     <= bus.d_wdata;
                        end else begin
                            m_read_q    <= 1'b1;
                            m_write_q   <= 1'b0;
                            m_address_q <= bus.i_address;
                        end
                    end
                end
                ARB_ACCESS: begin
                    if (cnt == '0) begin
                        if (m_read_q) begin
                            if (grant == GRANT_I) i_data_q  <= m_data;
                            else                  d_rdata_q <= m_data;
                        end
                        i_ready_q <= (grant == GRANT_I);
                        d_ready_q <= (grant == GRANT_D);
                        m_read_q  <= 1'b0;
                        m_write_q <= 1'b0;
                        state     <= ARB_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ARB_RESP: begin
                    i_ready_q <= 1'b0;
                    d_ready_q <= 1'b0;
                    state     <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign m_data = m_write_q ? wdata_q : 'z;

    assign bus.m_read    = m_read_q;
    assign bus.m_write   = m_write_q;
    assign bus.m_address = m_address_q;
    assign bus.i_data    = i_data_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;

    // Stalls are combinational so the pipeline releases in the ready cycle.
    assign bus.stall_if  = bus.i_read & ~i_ready_q;
    assign bus.stall_mem = d_req & ~d_ready_q;

endmodule
